// File: rtl/cmp_sar_search_pkg.sv
// Shared constants for the successive-approximation search engine:
// FSM state encoding and comparison-mode encoding.
package cmp_sar_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/cmp_sar_search_if.sv
// Query/response bundle between a requester, the search engine and a
// "target < probe" responder.
interface cmp_sar_search_if #(
  parameter int WIDTH = 32
);
  // Handshake: a probe is offered while probe_valid=1 and held stable until
  // the cycle in which resp_valid=1. That cycle consumes the answer in
  // resp_lt. resp_valid is ignored while probe_valid=0. A combinational
  // same-cycle answer is legal.
  logic             start;
  logic             abort;
  logic             is_signed;
  logic             busy;
  logic             probe_valid;
  logic [WIDTH-1:0] probe;
  logic             resp_valid;
  logic             resp_lt;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             done;

  modport master (
    output start, abort, is_signed, resp_valid, resp_lt,
    input  busy, probe_valid, probe, result, result_valid, done
  );

  modport slave (
    input  start, abort, is_signed, resp_valid, resp_lt,
    output busy, probe_valid, probe, result, result_valid, done
  );

endinterface

// File: rtl/cmp_sar_search.sv
// Successive-approximation search: recovers a WIDTH-bit target one bit per
// answered probe, MSB first, in signed or unsigned ordering.
module cmp_sar_search
  import cmp_sar_search_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_sar_search_if.slave  bus,
  output state_e           state_o
);

  localparam int            KW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_MSB = KW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [KW-1:0]    k_q, k_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rv_q, rv_d;
  logic             bit_val;
  logic [WIDTH-1:0] probe_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      k_q      <= K_MSB;
      mode_q   <= MODE_UNSIGNED;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      k_q      <= k_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  // In signed ordering the sign bit is set when the target is below zero,
  // which inverts the sense of the answer for the first probe only.
  assign bit_val = (k_q == K_MSB && mode_q == MODE_SIGNED) ? bus.resp_lt : ~bus.resp_lt;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    k_d      = k_q;
    mode_d   = mode_q;
    result_d = result_q;
    rv_d     = rv_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mode_d  = bus.is_signed;
            rv_d    = 1'b0;
            k_d     = K_MSB;
            cur_d   = '0;
            state_d = ST_QUERY;
          end
        end
        ST_QUERY: begin
          if (bus.resp_valid) begin
            cur_d[k_q] = bit_val;
            if (k_q == '0) begin
              result_d = cur_d;
              rv_d     = 1'b1;
              state_d  = ST_DONE;
            end else begin
              k_d = k_q - 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Lower bits of cur are still zero below k, so OR-ing the bit mask in
  // yields the midpoint of the remaining interval.
  always_comb begin
    probe_w = '0;
    if (state_q == ST_QUERY) begin
      if (k_q == K_MSB) begin
        probe_w = (mode_q == MODE_SIGNED) ? '0 : (WIDTH'(1) << K_MSB);
      end else begin
        probe_w = cur_q | (WIDTH'(1) << k_q);
      end
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.probe_valid  = (state_q == ST_QUERY);
  assign bus.probe        = probe_w;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.done         = (state_q == ST_DONE);
  assign state_o          = state_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
// Bench for cmp_sar_search at WIDTH=8 with a comparator-style responder and
// an interval-halving reference model.
module tb_cmp_sar_search;
  import cmp_sar_search_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  cmp_sar_search_if #(.WIDTH(W)) bus ();

  cmp_sar_search #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- responder ----------------
  logic [W-1:0] tb_target;
  logic         tb_mode;
  int           resp_delay;
  int           wcnt;

  assign bus.resp_lt    = tb_mode ? ($signed(tb_target) < $signed(bus.probe)) : (tb_target < bus.probe);
  assign bus.resp_valid = bus.probe_valid && (wcnt == resp_delay);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                wcnt <= 0;
    else if (!bus.probe_valid || bus.resp_valid) wcnt <= 0;
    else                                       wcnt <= wcnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_res;
  logic [W-1:0] last_result;
  int           total;
  int           bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Plain interval halving over the integer range of the chosen ordering.
  task automatic build_model(input logic [W-1:0] tgt, input logic sgn);
    int lo, hi, p, t;
    exp_q.delete();
    if (sgn) begin
      lo = -128; hi = 127; t = int'($signed(tgt));
    end else begin
      lo = 0; hi = 255; t = int'(tgt);
    end
    while (lo < hi) begin
      p = lo + (hi - lo + 1) / 2;
      exp_q.push_back(W'(p));
      if (t < p) hi = p - 1;
      else       lo = p;
    end
    model_res = W'(lo);
  endtask

  // ---------------- driver tasks ----------------
  task automatic kick(input logic [W-1:0] tgt, input logic sgn, input int d);
    tb_target  = tgt;
    tb_mode    = sgn;
    resp_delay = d;
    build_model(tgt, sgn);
    @(negedge clk);
    bus.is_signed = sgn;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_search(input logic [W-1:0] tgt, input logic sgn, input int d);
    int           cyc;
    logic         waiting;
    logic [W-1:0] held;
    kick(tgt, sgn, d);
    cyc     = 1;
    waiting = 1'b0;
    held    = '0;
    while (cyc <= 200 && !bus.done) begin
      if (bus.probe_valid) begin
        if (waiting) check("probe_hold", 32'(bus.probe), 32'(held));
        if (bus.resp_valid) begin
          if (exp_q.size() == 0) check("extra_probe", 32'(bus.probe), 32'hFFFF_FFFF);
          else check("probe", 32'(bus.probe), 32'(exp_q.pop_front()));
          waiting = 1'b0;
        end else begin
          waiting = 1'b1;
          held    = bus.probe;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) begin
      check("done_timeout", 32'(0), 32'(1));
    end else begin
      check("done_cycle", 32'(cyc), 32'(W * (1 + d) + 1));
      check("result_model", 32'(bus.result), 32'(model_res));
      check("result_target", 32'(bus.result), 32'(tgt));
      check("result_valid", 32'(bus.result_valid), 32'(1));
      check("busy_in_done", 32'(bus.busy), 32'(1));
      check("probes_left", 32'(exp_q.size()), 32'(0));
      last_result = tgt;
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'(0));
      check("idle_busy", 32'(bus.busy), 32'(0));
      check("result_hold", 32'(bus.result), 32'(tgt));
      check("rv_hold", 32'(bus.result_valid), 32'(1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total      = 0;
    bad        = 0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.is_signed = 1'b0;
    tb_target  = '0;
    tb_mode    = 1'b0;
    resp_delay = 0;
    last_result = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_pv", 32'(bus.probe_valid), 32'(0));
    check("rst_probe", 32'(bus.probe), 32'(0));
    check("rst_result", 32'(bus.result), 32'(0));
    check("rst_rv", 32'(bus.result_valid), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // directed scenarios
    run_search(8'hA5, 1'b0, 0);
    run_search(8'hFD, 1'b1, 0);
    run_search(8'h00, 1'b0, 0);
    run_search(8'hFF, 1'b0, 0);
    run_search(8'h80, 1'b1, 0);
    run_search(8'h7F, 1'b1, 0);
    run_search(8'h5A, 1'b0, 3);

    // abort after the 4th probe, with a start pulse while busy
    kick(8'h3C, 1'b0, 0);
    for (int c = 1; c <= 4; c++) begin
      check("abort_probe", 32'(bus.probe), 32'(exp_q.pop_front()));
      bus.start = (c == 2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_rv", 32'(bus.result_valid), 32'(0));
    check("abort_pv", 32'(bus.probe_valid), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    check("abort_result", 32'(bus.result), 32'(last_result));

    // abort and start together: abort wins
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", 32'(bus.busy), 32'(0));
    run_search(8'h3C, 1'b0, 0);

    // asynchronous reset mid-search
    kick(8'h96, 1'b1, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(bus.busy), 32'(0));
    check("mrst_pv", 32'(bus.probe_valid), 32'(0));
    check("mrst_probe", 32'(bus.probe), 32'(0));
    check("mrst_result", 32'(bus.result), 32'(0));
    check("mrst_rv", 32'(bus.result_valid), 32'(0));
    check("mrst_done", 32'(bus.done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_search(8'h96, 1'b1, 1);

    // randomized searches
    for (int i = 0; i < 20; i++) begin
      run_search(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
